// File: rtl/r4mul_pkg.sv
// Shared FSM/digit types and width helpers for the radix-4 Booth sequential multiplier.
// Signed operand support in the users of this package is enabled by R4_BOOTH_SIGNED_EN.
package r4mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        DIG_ZERO = 3'd0,
        DIG_POS1 = 3'd1,
        DIG_POS2 = 3'd2,
        DIG_NEG1 = 3'd3,
        DIG_NEG2 = 3'd4
    } digit_t;

    // Booth window width and the number of guard bits added above the multiplier.
    localparam int R4_WIN_W = 3;
    localparam int R4_EXT_W = 2;

    function automatic int r4_iters(input int dwidth);
        return dwidth / 2 + 1;
    endfunction

    function automatic int r4_cnt_w(input int dwidth);
        return $clog2(dwidth / 2 + 1) + 1;
    endfunction

endpackage

// File: rtl/r4_booth_enc.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window {b(2i+1), b(2i), b(2i-1)}
// to one signed digit in {0, +-1, +-2}.
module r4_booth_enc
    import r4mul_pkg::*;
(
    input  logic [R4_WIN_W-1:0] win_i,
    output digit_t              dig_o
);

    always_comb begin
        dig_o = DIG_ZERO;
        case (win_i)
            3'b001, 3'b010: dig_o = DIG_POS1;
            3'b011:         dig_o = DIG_POS2;
            3'b100:         dig_o = DIG_NEG2;
            3'b101, 3'b110: dig_o = DIG_NEG1;
            default:        dig_o = DIG_ZERO;
        endcase
    end

endmodule

// File: rtl/r4_booth_seq_mul.sv
// Sequential radix-4 Booth multiplier: one Booth digit per CALC cycle, valid/ready on both sides.
// Define R4_BOOTH_SIGNED_EN to honour sgn_in; otherwise all operands are treated as unsigned.
module r4_booth_seq_mul
    import r4mul_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int OWIDTH = 2 * DWIDTH
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] x_in,
    input  logic [DWIDTH-1:0] y_in,
    input  logic              sgn_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OWIDTH-1:0] z_out,
    output logic              busy
);

    localparam int N     = r4_iters(DWIDTH);
    localparam int CNT_W = r4_cnt_w(DWIDTH);
    // Multiplier shift register: guard bits, operand, and the implicit b(-1) = 0.
    localparam int MUL_W = DWIDTH + R4_EXT_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    state_t                   state_q, state_d;
    logic [DWIDTH-1:0]        x_q, x_d;
    logic [MUL_W-1:0]         mul_q, mul_d;
    logic signed [OWIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [OWIDTH-1:0]        z_q, z_d;

    logic [R4_EXT_W-1:0]      mul_ext;
    logic signed [OWIDTH-1:0] x_ext;
    logic signed [OWIDTH-1:0] pp;
    logic signed [OWIDTH-1:0] acc_sum;
    digit_t                   dig;

    // Partial product for one digit; all arithmetic is modulo 2^OWIDTH, which is exact
    // because the final product always fits in OWIDTH bits.
    function automatic logic signed [OWIDTH-1:0] booth_pp(
        input digit_t                   d,
        input logic signed [OWIDTH-1:0] x
    );
        logic signed [OWIDTH-1:0] r;
        case (d)
            DIG_POS1: r = x;
            DIG_POS2: r = x <<< 1;
            DIG_NEG1: r = -x;
            DIG_NEG2: r = -(x <<< 1);
            default:  r = '0;
        endcase
        return r;
    endfunction

`ifdef R4_BOOTH_SIGNED_EN
    logic sgn_q, sgn_d;

    assign mul_ext = {R4_EXT_W{sgn_in & y_in[DWIDTH-1]}};
    assign x_ext   = {{(OWIDTH-DWIDTH){sgn_q & x_q[DWIDTH-1]}}, x_q};
    assign sgn_d   = (state_q == ST_IDLE && in_valid) ? sgn_in : sgn_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sgn_q <= 1'b0;
        end else begin
            sgn_q <= sgn_d;
        end
    end
`else
    logic unused_sgn;

    assign unused_sgn = sgn_in;
    assign mul_ext    = '0;
    assign x_ext      = {{(OWIDTH-DWIDTH){1'b0}}, x_q};
`endif

    r4_booth_enc u_enc (
        .win_i (mul_q[R4_WIN_W-1:0]),
        .dig_o (dig)
    );

    assign pp      = booth_pp(dig, x_ext) <<< {cnt_q, 1'b0};
    assign acc_sum = acc_q + pp;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        mul_d     = mul_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        z_d       = z_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    x_d     = x_in;
                    mul_d   = {mul_ext, y_in, 1'b0};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                acc_d = acc_sum;
                mul_d = mul_q >> 2;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    z_d     = acc_sum;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            mul_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            mul_q   <= mul_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
        end
    end

    assign z_out = z_q;

endmodule

// File: tb/tb_r4_booth_seq_mul.sv
// Scoreboard bench for r4_booth_seq_mul (DWIDTH=8); expected products follow R4_BOOTH_SIGNED_EN.
module tb_r4_booth_seq_mul;

`ifdef R4_BOOTH_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  x_in;
    logic [7:0]  y_in;
    logic        sgn_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] z_out;
    logic        busy;

    typedef struct {
        logic [15:0] z;
        int          acc_cyc;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   tests   = 0;
    int   fails   = 0;
    int   cyc     = 0;
    bit   lat_done = 1'b0;

    r4_booth_seq_mul #(.DWIDTH(8), .OWIDTH(16)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .sgn_in    (sgn_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z_out     (z_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: latency on first sight of out_valid, product on handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstn && out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious out_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    if (!lat_done) begin
                        chk({sb[0].nm, " latency"}, cyc - sb[0].acc_cyc, 32'd6);
                        lat_done = 1'b1;
                    end
                    if (out_ready) begin
                        e = sb.pop_front();
                        chk({e.nm, " z_out"}, {16'd0, z_out}, {16'd0, e.z});
                        lat_done = 1'b0;
                    end
                end
            end
        end
    end

    task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic s,
                         input logic [15:0] z, input string nm);
        int   w = 0;
        exp_t e;
        @(negedge clk);
        x_in = x; y_in = y; sgn_in = s; in_valid = 1'b1;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            chk({nm, " accept timeout"}, {31'd0, in_ready}, 32'd1);
        end else begin
            e.z = z; e.acc_cyc = cyc; e.nm = nm;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int w = 0;
        while ((sb.size() != 0 || busy) && w < 60) begin
            @(negedge clk);
            w++;
        end
        chk({nm, " drained"}, {31'd0, (sb.size() == 0 && !busy)}, 32'd1);
    endtask

    initial begin
        int w;
        rstn = 1'b0; in_valid = 1'b0; x_in = '0; y_in = '0; sgn_in = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset in_ready",  {31'd0, in_ready},  32'd1);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset busy",      {31'd0, busy},      32'd0);
        chk("reset z_out",     {16'd0, z_out},     32'd0);
        rstn = 1'b1;

        issue(8'd13, 8'd11, 1'b0, 16'h008F, "u 13*11");
        drain("u 13*11");
        chk("idle z_out held", {16'd0, z_out},    32'h008F);
        chk("idle in_ready",   {31'd0, in_ready}, 32'd1);

        issue(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u FF*FF");
        issue(8'hFF, 8'hFF, 1'b1, SIGNED_EN ? 16'h0001 : 16'hFE01, "s FF*FF");
        issue(8'h80, 8'h80, 1'b1, 16'h4000, "s 80*80");
        issue(8'hFD, 8'h05, 1'b1, SIGNED_EN ? 16'hFFF1 : 16'h04F1, "s FD*05");
        issue(8'h7F, 8'h80, 1'b1, SIGNED_EN ? 16'hC080 : 16'h3F80, "s 7F*80");
        issue(8'h12, 8'h34, 1'b0, 16'h03A8, "u 12*34");
        issue(8'h00, 8'hAB, 1'b0, 16'h0000, "u 00*AB");
        drain("burst");

        // Back-pressure: hold DONE for 5 cycles with a competing operand offer.
        out_ready = 1'b0;
        issue(8'h0C, 8'h0A, 1'b0, 16'h0078, "u 0C*0A hold");
        w = 0;
        while (!out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("hold out_valid seen", {31'd0, out_valid}, 32'd1);
        x_in = 8'h55; y_in = 8'h55; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold z_out",     {16'd0, z_out},     32'h0078);
            chk("hold in_ready",  {31'd0, in_ready},  32'd0);
        end
        @(posedge clk);
        #1 in_valid = 1'b0; out_ready = 1'b1;
        drain("hold");

        // Reset during the second CALC cycle discards the operation.
        @(negedge clk);
        x_in = 8'h21; y_in = 8'h43; sgn_in = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("pre-reset busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk("mid reset in_ready",  {31'd0, in_ready},  32'd1);
        chk("mid reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid reset busy",      {31'd0, busy},      32'd0);
        chk("mid reset z_out",     {16'd0, z_out},     32'd0);
        rstn = 1'b1;
        sb.delete();
        lat_done = 1'b0;
        issue(8'h07, 8'h09, 1'b0, 16'h003F, "u 7*9 after reset");
        drain("after reset");

        repeat (3) @(negedge clk);
        chk("scoreboard empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/r4_booth_seq_mul.md
R4_BOOTH_SEQ_MUL -- requirements
Module: r4_booth_seq_mul

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, operand width; even and >= 4.
REQ-002 SHALL have parameter OWIDTH, default 2*DWIDTH, product width; fixed to 2*DWIDTH.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rstn  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand pair offered.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port x_in  input  DWIDTH  multiplicand.
REQ-008 SHALL have port y_in  input  DWIDTH  multiplier.
REQ-009 SHALL have port sgn_in  input  1  1 = two's-complement operands, 0 = unsigned; sampled with operands.
REQ-010 SHALL have port out_valid  output  1  z_out holds a valid product.
REQ-011 SHALL have port out_ready  input  1  consumer takes product.
REQ-012 SHALL have port z_out  output  OWIDTH  product.
REQ-013 SHALL have port busy  output  1  high in CALC and DONE.

Function
REQ-014 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE.
REQ-015 SHALL drive in_ready high only in IDLE; accept = in_valid & in_ready at a rising edge.
REQ-016 SHALL on accept register x_in, y_in, sgn_in, clear accumulator and iteration counter, enter CALC.
REQ-017 SHALL extend the multiplier to DWIDTH+2 bits (sign-extended if sgn, zero-extended otherwise) and retire one radix-4 Booth digit {0,+-1,+-2}*X per CALC cycle.
REQ-018 SHALL run exactly N = DWIDTH/2+1 CALC cycles, then enter DONE.
REQ-019 SHALL assert out_valid exactly N+1 cycles after the accepting edge, and only in DONE.
REQ-020 SHALL hold z_out and out_valid stable in DONE while out_ready is low, for any duration.
REQ-021 SHALL return to IDLE on the edge where out_valid & out_ready; no new accept in that same cycle.
REQ-022 SHALL produce z_out equal to the exact OWIDTH-bit product in the selected signedness; no overflow possible.
REQ-023 SHALL ignore in_valid, x_in, y_in, sgn_in outside IDLE.
REQ-024 SHALL keep z_out at its last product in IDLE (zero after reset).

Reset
REQ-025 SHALL on rstn low at any edge, including mid-CALC or in DONE, enter IDLE and discard the operation.
REQ-026 SHALL reset values: in_ready 1 (IDLE), out_valid 0, busy 0, z_out 0, counter 0, operand registers 0.

Configuration
REQ-027 SHALL compile signed support only when macro R4_BOOTH_SIGNED_EN is defined: with it, sgn_in selects per REQ-017; without it, sgn_in is ignored, all operands treated unsigned, and no sign-extension logic is synthesised.

Structure
REQ-028 SHALL place in shared package r4mul_pkg: FSM state enum, Booth digit encoding type (zero/pos1/pos2/neg1/neg2), and width helper constants.
REQ-029 SHALL use one combinational sub-module r4_booth_enc mapping a 3-bit multiplier window to a digit.
REQ-030 SHALL keep the counter CLOG2(N)+1 bits wide.

Verification (DWIDTH=8)
REQ-031 SHALL check unsigned 13*11 -> z_out 0x008F, out_valid exactly 6 cycles after accept.
REQ-032 SHALL check unsigned 255*255 -> 0xFE01; signed (macro on) 0xFF*0xFF -> 0x0001.
REQ-033 SHALL check signed 0x80*0x80 -> 0x4000; signed -3*5 (0xFD,0x05) -> 0xFFF1.
REQ-034 SHALL check out_ready low for 5 cycles in DONE -> z_out/out_valid held; in_valid during this time ignored (in_ready 0).
REQ-035 SHALL check rstn low in CALC cycle 2 -> next cycle IDLE, out_valid 0, z_out 0; next operands 7*9 -> 0x003F.
REQ-036 SHALL check macro off with sgn_in=1, 0xFD*0x05 -> 0x04F1 (unsigned).
